// File: rtl/snake_matrix_renderer.sv
`default_nettype none
// ============================================================================
// Module      : snake_matrix_renderer
// Description : Collects one frame of snake segment positions into a 64-pixel
//               back buffer. On frame_done it commits that buffer and the apple
//               position to front buffers in a single step. The front buffers
//               are scanned onto an 8x8 bicolour LED matrix, one row per slot.
// Ports       :
//   clock        in   system clock
//   restart      in   asynchronous active-high reset
//   frame_start  in   pulse: clear back buffer, open a frame
//   seg_valid    in   seg_pos carries a snake segment this cycle
//   seg_pos      in   {row[5:3], col[2:0]} segment position
//   apple_pos    in   apple position, sampled on commit
//   apple_show   in   apple drawn if high at commit
//   frame_done   in   pulse: commit back buffer and apple to front buffers
//   row_sel      out  one-hot row drive
//   col_snake    out  green columns of the selected row
//   col_apple    out  red columns of the selected row
//   busy         out  frame open
//   dup_segment  out  sticky: a segment landed on an already-set pixel
//   frames       out  committed-frame counter (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module snake_matrix_renderer #(
    parameter int SCAN_DIV = 5000
) (
    input  logic       clock,
    input  logic       restart,
    input  logic       frame_start,
    input  logic       seg_valid,
    input  logic [5:0] seg_pos,
    input  logic [5:0] apple_pos,
    input  logic       apple_show,
    input  logic       frame_done,
    output logic [7:0] row_sel,
    output logic [7:0] col_snake,
    output logic [7:0] col_apple,
    output logic       busy,
    output logic       dup_segment,
    output logic [5:0] frames
);

    localparam logic [19:0] C_PRESC_MAX = 20'(SCAN_DIV - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    state_t      state_q,       state_d;
    logic [63:0] back_q,        back_d;
    logic [63:0] front_snake_q, front_snake_d;
    logic [63:0] front_apple_q, front_apple_d;
    logic        dup_q,         dup_d;
    logic [5:0]  frames_q,      frames_d;
    logic [19:0] presc_q,       presc_d;
    logic [2:0]  row_q,         row_d;

    // Frame accumulation and commit
    always_comb begin
        state_d       = state_q;
        back_d        = back_q;
        front_snake_d = front_snake_q;
        front_apple_d = front_apple_q;
        dup_d         = dup_q;
        frames_d      = frames_q;

        if (frame_start) begin
            // frame_start beats a same-cycle frame_done; a same-cycle segment
            // lands in the freshly cleared buffer and cannot be a duplicate.
            back_d  = 64'd0;
            dup_d   = 1'b0;
            state_d = ST_ACCUM;
            if (seg_valid) begin
                back_d[seg_pos] = 1'b1;
            end
        end else if (state_q == ST_ACCUM) begin
            if (seg_valid) begin
                if (back_q[seg_pos]) begin
                    dup_d = 1'b1;
                end
                back_d[seg_pos] = 1'b1;
            end
            if (frame_done) begin
                // back_d already holds any segment arriving with frame_done
                front_snake_d = back_d;
                front_apple_d = apple_show ? (64'd1 << apple_pos) : 64'd0;
                frames_d      = frames_q + 6'd1;
                state_d       = ST_IDLE;
            end
        end
    end

    // Row scan: prescaler free-runs independently of frame activity
    always_comb begin
        presc_d = presc_q + 20'd1;
        row_d   = row_q;
        if (presc_q == C_PRESC_MAX) begin
            presc_d = 20'd0;
            row_d   = row_q + 3'd1;
        end
    end

    always_ff @(posedge clock or posedge restart) begin
        if (restart) begin
            state_q       <= ST_IDLE;
            back_q        <= 64'd0;
            front_snake_q <= 64'd0;
            front_apple_q <= 64'd0;
            dup_q         <= 1'b0;
            frames_q      <= 6'd0;
            presc_q       <= 20'd0;
            row_q         <= 3'd0;
        end else begin
            state_q       <= state_d;
            back_q        <= back_d;
            front_snake_q <= front_snake_d;
            front_apple_q <= front_apple_d;
            dup_q         <= dup_d;
            frames_q      <= frames_d;
            presc_q       <= presc_d;
            row_q         <= row_d;
        end
    end

    // Outputs depend on registers only
    assign row_sel     = 8'd1 << row_q;
    assign col_snake   = front_snake_q[{row_q, 3'b000} +: 8];
    assign col_apple   = front_apple_q[{row_q, 3'b000} +: 8];
    assign busy        = (state_q == ST_ACCUM);
    assign dup_segment = dup_q;
    assign frames      = frames_q;

endmodule
`default_nettype wire

// File: doc/snake_matrix_renderer.md
# snake_matrix_renderer

Downstream display stage of the Snake Game Arcade datapath. It accepts the per-frame stream of snake segment positions produced by the render sweep of the snake RAM, plus the current apple position. It accumulates them into a 64-pixel back buffer and commits it atomically to a front buffer. The front buffer is time-multiplexed onto an 8x8 bicolour LED matrix, one row per scan slot.

## Interface
- SCAN_DIV, 5000: clock cycles each row stays lit; legal range 2..2^20-1.
- clock  in  1  system clock; all state changes on rising edge.
- restart  in  1  reset, asynchronous and active-high.
- frame_start  in  1  one-cycle pulse; clears back buffer and opens a new frame.
- seg_valid  in  1  seg_pos holds a snake segment this cycle.
- seg_pos  in  6  segment position {row[5:3], col[2:0]}.
- apple_pos  in  6  apple position, same encoding; sampled on commit only.
- apple_show  in  1  apple is drawn if high at commit.
- frame_done  in  1  one-cycle pulse; commits back buffer and apple to front buffer.
- row_sel  out  8  one-hot active-high row drive; bit r = row r.
- col_snake  out  8  green columns of the selected row; bit c = column c.
- col_apple  out  8  red columns of the selected row.
- busy  out  1  high while a frame is open (ACCUM).
- dup_segment  out  1  sticky; a segment hit an already-set back-buffer pixel this frame.
- frames  out  6  committed-frame counter, wraps 63->0 (debug).

## Operation
- FSM states: IDLE, ACCUM. Reset -> IDLE.
- IDLE: seg_valid and frame_done are ignored. frame_start -> ACCUM.
- ACCUM:
  - seg_valid sets back[seg_pos]. If that bit is already 1, dup_segment goes to 1.
  - frame_done copies back -> front_snake.
  - On frame_done, front_apple is loaded with one bit at apple_pos when apple_show=1, otherwise all zero.
  - On frame_done, frames increments and the FSM goes to IDLE.
  - frame_start -> restart the frame: clear back, clear dup_segment, stay in ACCUM.
- frame_start in any state clears the 64-bit back buffer and dup_segment in one cycle.
- Simultaneous events:
  - frame_start + seg_valid: the buffer is cleared, then that segment is written. dup_segment = 0 after the edge.
  - frame_done + seg_valid: the segment is included in the committed frame.
  - frame_start + frame_done in ACCUM: frame_start wins. There is no commit, frames is unchanged, and the FSM stays in ACCUM with a cleared buffer.
- Apple and snake on the same pixel: both colour bits are set (yellow). This is not an error.
- Front buffers change only on commit. Back-buffer activity never disturbs the displayed image.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 continuously.
  - At terminal count the prescaler goes to 0 and the row index increments mod 8 (7->0).
  - row_sel = 1<<row.
  - col_snake = front_snake row slice; col_apple = front_apple row slice.

## Timing
- Reset values:
  - IDLE, busy=0, dup_segment=0, frames=0.
  - Prescaler 0, row index 0, so row_sel=8'b00000001.
  - Both front buffers and the back buffer are 0, so col_snake=col_apple=0.
- busy is registered: it rises the cycle after frame_start is sampled and falls the cycle after frame_done is sampled.
- Commit latency: the front buffer updates on the edge sampling frame_done. col_* reflect the new image in the cycle after that edge, provided the row is selected.
- dup_segment rises the cycle after the offending seg_valid edge.
- Each row is lit for exactly SCAN_DIV cycles; one full matrix refresh = 8*SCAN_DIV cycles.
- row_sel and col_* are combinational from registers only. There is no input-to-output combinational path.
- restart mid-frame: everything returns to reset values immediately, regardless of clock. The open frame is discarded.

## Test plan
- Reset: assert restart mid-scan (SCAN_DIV=4).
  - During reset: row_sel=8'h01, col_snake=col_apple=0, busy=0, frames=0.
  - After release: row_sel=8'h02 exactly 4 cycles after release.
- Basic frame: frame_start; segments 6'o00, 6'o01, 6'o11; apple_pos=6'o77, apple_show=1; frame_done.
  - Row 0 slot: col_snake=8'h03.
  - Row 1 slot: col_snake=8'h02.
  - Row 7 slot: col_apple=8'h80.
  - frames=1, busy=0.
- Duplicate: frame_start; seg 6'o23 twice -> dup_segment=1 the cycle after the second. Next frame_start -> dup_segment=0.
- Atomic commit: frame A committed, then a frame B accumulation is open. The display keeps showing A until B's frame_done, then switches to B one cycle later. seg_valid while IDLE -> no change.
- Priority: frame_start and frame_done in the same cycle during ACCUM -> frames unchanged, busy stays 1, back buffer cleared. seg_valid with frame_done -> that pixel appears in front.
- Wrap: commit 64 frames -> frames returns to 0. Apple_show=0 with a snake segment on the apple cell -> col_apple=0, green only.
